// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard controller: FSM state
// encoding, the register-zero constant and the bundled control-output struct.
package pipe_hazard_ctrl_pkg;

  typedef enum logic {
    ST_RUN     = 1'b0,
    ST_MD_WAIT = 1'b1
  } state_e;

  localparam logic [4:0] REG_ZERO = 5'd0;

  typedef struct packed {
    logic pc_wen;
    logic ifid_wen;
    logic ifid_flush;
    logic idex_wen;
    logic idex_flush;
    logic exmem_flush;
    logic md_busy;
  } ctrl_t;

  // Free-running pipeline: every register advances, nothing is cleared.
  localparam ctrl_t CTRL_RUN = '{
    pc_wen: 1'b1, ifid_wen: 1'b1, ifid_flush: 1'b0, idex_wen: 1'b1,
    idex_flush: 1'b0, exmem_flush: 1'b0, md_busy: 1'b0
  };

  // Held in reset: nothing written, every pipeline register cleared.
  localparam ctrl_t CTRL_RESET = '{
    pc_wen: 1'b0, ifid_wen: 1'b0, ifid_flush: 1'b1, idex_wen: 1'b0,
    idex_flush: 1'b1, exmem_flush: 1'b1, md_busy: 1'b0
  };

  // Mult/div holding EX: front end frozen, bubble issued into EX/MEM.
  localparam ctrl_t CTRL_MD_STALL = '{
    pc_wen: 1'b0, ifid_wen: 1'b0, ifid_flush: 1'b0, idex_wen: 1'b0,
    idex_flush: 1'b0, exmem_flush: 1'b1, md_busy: 1'b1
  };

endpackage

// File: rtl/pipe_hazard_ctrl_sat_counter.sv
// Saturating up-counter with enable and asynchronous active-low clear;
// holds at all-ones once reached.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en,
  output logic [W-1:0] count
);

  logic [W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (en && (count_q != '1)) count_d = count_q + W'(1);
  end

  // NOTE: state registers use non-blocking assignment so every flop samples
  // its pre-edge value regardless of process evaluation order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) count_q <= '0;
    else        count_q <= count_d;
  end

  assign count = count_q;

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Hazard controller for a 5-stage pipeline: load-use stalls, taken-branch
// flushes and multi-cycle mult/div occupancy of EX. Outputs are Mealy.
module pipe_hazard_ctrl
  import pipe_hazard_ctrl_pkg::*;
#(
  parameter int MD_LAT = 4,   // total EX occupancy of a mult/div, 2..16
  parameter int CNT_W  = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [4:0]       id_rs,
  input  logic [4:0]       id_rt,
  input  logic             id_use_rs,
  input  logic             id_use_rt,
  input  logic             ex_memread,
  input  logic [4:0]       ex_rd,
  input  logic             ex_md,
  input  logic             branch_taken,
  output logic             pc_wen,
  output logic             ifid_wen,
  output logic             ifid_flush,
  output logic             idex_wen,
  output logic             idex_flush,
  output logic             exmem_flush,
  output logic             md_busy,
  output logic [CNT_W-1:0] stall_cycles
);

  state_e     st_q, st_d;
  logic [3:0] md_cnt_q, md_cnt_d;
  logic       lu_haz;
  ctrl_t      ctrl;

  assign lu_haz = ex_memread && (ex_rd != REG_ZERO) &&
                  ((id_use_rs && (id_rs == ex_rd)) || (id_use_rt && (id_rt == ex_rd)));

  // NOTE: every signal written here gets a default first, so no path through
  // the block leaves a value unassigned and no latch is inferred.
  always_comb begin
    st_d     = st_q;
    md_cnt_d = md_cnt_q;
    ctrl     = CTRL_RUN;
    if (!reset) begin
      ctrl = CTRL_RESET;
    end else begin
      unique case (st_q)
        ST_RUN: begin
          if (branch_taken) begin
            ctrl.ifid_flush = 1'b1;
            ctrl.idex_flush = 1'b1;
          end else if (ex_md) begin
            ctrl     = CTRL_MD_STALL;
            md_cnt_d = 4'(MD_LAT - 2);
            st_d     = ST_MD_WAIT;
          end else if (lu_haz) begin
            ctrl.pc_wen     = 1'b0;
            ctrl.ifid_wen   = 1'b0;
            ctrl.idex_flush = 1'b1;
          end
        end
        ST_MD_WAIT: begin
          // Release cycle keeps md_busy high while the result leaves EX.
          if (md_cnt_q != 4'd0) begin
            ctrl     = CTRL_MD_STALL;
            md_cnt_d = md_cnt_q - 4'd1;
          end else begin
            ctrl.md_busy = 1'b1;
            st_d         = ST_RUN;
          end
        end
        default: st_d = ST_RUN;
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      st_q     <= ST_RUN;
      md_cnt_q <= 4'd0;
    end else begin
      st_q     <= st_d;
      md_cnt_q <= md_cnt_d;
    end
  end

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk   (clock),
    .rst_n (reset),
    .en    (reset && !ctrl.pc_wen),
    .count (stall_cycles)
  );

  assign pc_wen      = ctrl.pc_wen;
  assign ifid_wen    = ctrl.ifid_wen;
  assign ifid_flush  = ctrl.ifid_flush;
  assign idex_wen    = ctrl.idex_wen;
  assign idex_flush  = ctrl.idex_flush;
  assign exmem_flush = ctrl.exmem_flush;
  assign md_busy     = ctrl.md_busy;

  // A branch cannot resolve while EX is held by a mult/div.
  a_no_branch_in_md_wait : assert property (
    @(posedge clock) disable iff (!reset) !((st_q == ST_MD_WAIT) && branch_taken)
  );

endmodule
